// File: rtl/collision_probe_seq.sv
// Eight-point wall-collision probe for a sprite against a colour-coded map ROM.
// One request at a time: eight ROM reads, one-cycle result pulse, 11 cycles total.
module collision_probe_seq #(
   parameter int          MAP_W   = 200,
   parameter logic [23:0] WALL_C0 = 24'h716734,
   parameter logic [23:0] WALL_C1 = 24'h5f582b
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [6:0]  width,
   input  logic [6:0]  height,
   output logic [16:0] rom_addr,
   input  logic [23:0] rom_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_flags,
   output logic        busy
);

   localparam logic [19:0] MAP_W20 = 20'(MAP_W);

   typedef enum logic [1:0] {IDLE, PROBE, WAIT, RESP} state_t;

   state_t      state, state_nx;
   logic [2:0]  idx;
   logic [9:0]  cx, cy;
   logic [6:0]  hw, hh;
   logic [6:0]  flags_acc;

   logic        hit;
   logic [9:0]  yt, yb, px, py;
   logic [19:0] col, row, addr_full;

   assign hit = (rom_data == WALL_C0) || (rom_data == WALL_C1);

   // Probe point for the current index; all arithmetic wraps at 10 bits.
   always_comb begin
      yt = cy - {3'b000, hh};
      yb = cy + {3'b000, hh};
      px = cx;
      py = cy;
      unique case (idx)
         3'd0: py = yt;
         3'd1: py = yb;
         3'd2: px = cx - {3'b000, hw};
         3'd3: px = cx + {3'b000, hw};
         3'd4: begin px = cx - 10'd8; py = yb - 10'd4; end
         3'd5: begin px = cx + 10'd8; py = yb - 10'd4; end
         3'd6: begin px = cx - 10'd8; py = yt + 10'd4; end
         3'd7: begin px = cx + 10'd8; py = yt + 10'd4; end
      endcase
   end

   always_comb begin
      col       = ({10'b0, px} * 20'd5) >> 4;
      row       = ({10'b0, py} * 20'd5) >> 4;
      addr_full = col + row * MAP_W20;
   end

   assign rom_addr  = (state == PROBE) ? addr_full[16:0] : '0;
   assign req_ready = (state == IDLE);
   assign busy      = ~req_ready;
   assign rsp_valid = (state == RESP);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (req_valid) state_nx = PROBE;
         PROBE: if (idx == 3'd7) state_nx = WAIT;
         WAIT:  state_nx = RESP;
         RESP:  state_nx = IDLE;
      endcase
   end

   // ROM data lags the address by a cycle, so each PROBE step scores the previous index.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         idx       <= '0;
         cx        <= '0;
         cy        <= '0;
         hw        <= '0;
         hh        <= '0;
         flags_acc <= '0;
         rsp_flags <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  cx        <= x;
                  cy        <= y;
                  hw        <= width >> 1;
                  hh        <= height >> 1;
                  idx       <= '0;
                  flags_acc <= '0;
               end
            end
            PROBE: begin
               idx <= idx + 3'd1;
               if (idx != 3'd0) flags_acc[idx - 3'd1] <= hit;
            end
            WAIT: rsp_flags <= {hit, flags_acc};
            RESP: ;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_probe_seq.sv
// Randomized self-checking bench for collision_probe_seq with a behavioural map-ROM model.
module tb_collision_probe_seq;

   localparam int          MAP_W   = 200;
   localparam logic [23:0] WALL_C0 = 24'h716734;
   localparam logic [23:0] WALL_C1 = 24'h5f582b;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  x, y;
   logic [6:0]  width, height;
   logic [16:0] rom_addr;
   logic [23:0] rom_data = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_flags;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   // ROM content selector: 0 all empty, 1 all wall, 2 single hit, 3 hashed pattern
   int          rom_mode = 0;
   int          hit_addr = 0;
   logic [31:0] seed     = 32'h1234_5678;

   collision_probe_seq #(.MAP_W(MAP_W), .WALL_C0(WALL_C0), .WALL_C1(WALL_C1)) dut (
      .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
      .x(x), .y(y), .width(width), .height(height),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .rsp_valid(rsp_valid), .rsp_flags(rsp_flags), .busy(busy)
   );

   always #5 Clk = ~Clk;

   function automatic logic [23:0] rom_word(input int a);
      logic [31:0] h;
      case (rom_mode)
         1: return WALL_C1;
         2: return (a == hit_addr) ? WALL_C0 : 24'h000000;
         3: begin
            h = (32'(a) * 32'h9E3779B1) ^ seed;
            h = h ^ (h >> 15);
            case (h[1:0])
               2'd0: return WALL_C0;
               2'd1: return WALL_C1;
               2'd2: return WALL_C0 + 24'd1;
               default: return 24'h000000;
            endcase
         end
         default: return 24'h000000;
      endcase
   endfunction

   always @(posedge Clk) rom_data <= rom_word(int'(rom_addr));

   function automatic int probe_addr(input int i, input int rx, input int ry, input int rw, input int rh);
      int hw, hh, yt, yb, px, py;
      hw = rw / 2;  hh = rh / 2;
      yt = ry - hh; yb = ry + hh;
      px = rx;      py = ry;
      case (i)
         0: py = yt;
         1: py = yb;
         2: px = rx - hw;
         3: px = rx + hw;
         4: begin px = rx - 8; py = yb - 4; end
         5: begin px = rx + 8; py = yb - 4; end
         6: begin px = rx - 8; py = yt + 4; end
         default: begin px = rx + 8; py = yt + 4; end
      endcase
      px = px & 1023;
      py = py & 1023;
      return (((px * 5) >> 4) + ((py * 5) >> 4) * MAP_W) & 'h1FFFF;
   endfunction

   function automatic logic [7:0] exp_flags(input int rx, input int ry, input int rw, input int rh);
      logic [7:0] f;
      logic [23:0] w;
      for (int i = 0; i < 8; i++) begin
         w = rom_word(probe_addr(i, rx, ry, rw, rh));
         f[i] = (w == WALL_C0) || (w == WALL_C1);
      end
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_req(input int rx, input int ry, input int rw, input int rh, input string tag,
                          output logic [7:0] flags_seen, output int addr3);
      int         rsp_cyc = -1;
      int         pulses  = 0;
      logic [7:0] expf;
      flags_seen = '0;
      addr3      = -1;
      expf = exp_flags(rx, ry, rw, rh);
      @(negedge Clk);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      x = rx[9:0]; y = ry[9:0]; width = rw[6:0]; height = rh[6:0];
      req_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      req_valid = 1'b0;
      x = 10'(rx + 37); y = 10'(ry + 91); width = 7'(rw + 5); height = 7'(rh + 3);
      for (int c = 1; c <= 12; c++) begin
         if (c <= 8) check($sformatf("%s_addr%0d", tag, c - 1), 32'(rom_addr),
                           32'(probe_addr(c - 1, rx, ry, rw, rh)));
         if (c == 3) addr3 = int'(rom_addr);
         if (c == 1) check({tag, "_busy"}, {30'b0, busy, req_ready}, 32'd2);
         if (c == 9 || c == 10) check({tag, "_addr_idle"}, 32'(rom_addr), 32'd0);
         if (c == 11) begin
            check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
            check({tag, "_flags_hold"}, 32'(rsp_flags), 32'(expf));
         end
         if (rsp_valid === 1'b1) begin
            pulses++;
            rsp_cyc    = c;
            flags_seen = rsp_flags;
         end
         @(negedge Clk);
      end
      check({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'd10);
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_flags"}, 32'(flags_seen), 32'(expf));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] f;
      int         a3;
      int         pulses;
      int         rsp_cycles[$];
      logic [7:0] rsp_vals[$];
      int         x0, x1;
      logic [7:0] e0, e1;

      Reset = 1'b1; req_valid = 1'b0;
      x = '0; y = '0; width = '0; height = '0;
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp", {23'b0, rsp_valid, rsp_flags}, 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;

      // single hit
      rom_mode = 2; hit_addr = 5231;
      run_req(100, 100, 20, 30, "hit", f, a3);
      check("hit_const_flags", 32'(f), 32'h01);

      // all wall / all empty
      rom_mode = 1;
      run_req(500, 300, 40, 50, "allwall", f, a3);
      check("allwall_const", 32'(f), 32'hFF);
      rom_mode = 0;
      run_req(500, 300, 40, 50, "allzero", f, a3);
      check("allzero_const", 32'(f), 32'h00);

      // left-edge wrap
      rom_mode = 3; seed = 32'hCAFE_0001;
      run_req(3, 100, 20, 30, "wrap", f, a3);
      check("wrap_addr_const", 32'(a3), 32'd6517);

      // reset mid-request after a nonzero response
      rom_mode = 1;
      run_req(200, 200, 10, 10, "prerst", f, a3);
      @(negedge Clk);
      x = 10'd300; y = 10'd250; width = 7'd16; height = 7'd16; req_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      req_valid = 1'b0;
      repeat (4) @(negedge Clk);
      Reset = 1'b1;
      #1;
      check("mid_rst_ready", {30'b0, req_ready, busy}, 32'd2);
      check("mid_rst_rsp", {23'b0, rsp_valid, rsp_flags}, 32'd0);
      check("mid_rst_addr", 32'(rom_addr), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         if (rsp_valid === 1'b1) pulses++;
         @(negedge Clk);
      end
      check("mid_rst_no_pulse", 32'(pulses), 32'd0);
      rom_mode = 3; seed = 32'h0BAD_F00D;
      run_req(300, 250, 16, 16, "postrst", f, a3);

      // back-to-back with x changed mid-request
      rom_mode = 3; seed = 32'h5151_A0A0;
      x0 = 400; x1 = 620;
      e0 = exp_flags(x0, 480, 33, 41);
      e1 = exp_flags(x1, 480, 33, 41);
      @(negedge Clk);
      x = x0[9:0]; y = 10'd480; width = 7'd33; height = 7'd41; req_valid = 1'b1;
      @(posedge Clk);
      for (int c = 1; c <= 24; c++) begin
         @(negedge Clk);
         if (c == 3) x = x1[9:0];
         if (c == 11) check("b2b_ready11", 32'(req_ready), 32'd1);
         if (rsp_valid === 1'b1) begin
            rsp_cycles.push_back(c);
            rsp_vals.push_back(rsp_flags);
         end
         if (c == 21) req_valid = 1'b0;
      end
      check("b2b_count", 32'(rsp_cycles.size()), 32'd2);
      if (rsp_cycles.size() == 2) begin
         check("b2b_cyc0", 32'(rsp_cycles[0]), 32'd10);
         check("b2b_cyc1", 32'(rsp_cycles[1]), 32'd21);
         check("b2b_flags0", 32'(rsp_vals[0]), 32'(e0));
         check("b2b_flags1", 32'(rsp_vals[1]), 32'(e1));
      end

      // randomized requests
      for (int n = 0; n < 12; n++) begin
         rom_mode = 3;
         seed = $urandom;
         run_req(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                 $sformatf("rnd%0d", n), f, a3);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/collision_probe_seq.md
COLLISION_PROBE_SEQ -- requirements
Module: collision_probe_seq

Interface
REQ-001 SHALL have parameter MAP_W, default 200, meaning map ROM words per row.
REQ-002 SHALL have parameter WALL_C0, default 24'h716734, meaning first wall colour.
REQ-003 SHALL have parameter WALL_C1, default 24'h5f582b, meaning second wall colour.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; all other ports are synchronous to Clk.
REQ-005 SHALL have port Clk  in  1  system clock.
REQ-006 SHALL have port Reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have port req_valid  in  1  probe request present.
REQ-008 SHALL have port req_ready  out  1  block idle and accepting a request.
REQ-009 SHALL have ports x, y  in  10 each  object centre, pixels.
REQ-010 SHALL have ports width, height  in  7 each  object size, pixels.
REQ-011 SHALL have port rom_addr  out  17  map ROM read address.
REQ-012 SHALL have port rom_data  in  24  map ROM word, valid one cycle after rom_addr.
REQ-013 SHALL have port rsp_valid  out  1  one-cycle pulse, flags updated.
REQ-014 SHALL have port rsp_flags  out  8  bit0 up, 1 down, 2 left, 3 right, 4 left_end, 5 right_end, 6 left_top, 7 right_top.
REQ-015 SHALL have port busy  out  1  request in progress (inverse of req_ready).

Function
REQ-016 SHALL implement states IDLE, PROBE, WAIT and RESP.
REQ-017 SHALL accept a request on a rising edge with req_valid=1 in IDLE; it SHALL capture x, y, width and height, and go to PROBE with index 0.
REQ-018 SHALL assert req_ready only in IDLE; req_valid outside IDLE SHALL be ignored and not queued.
REQ-019 SHALL use only the captured values; input changes after acceptance SHALL have no effect.
REQ-020 SHALL, in PROBE, drive rom_addr for probe index i (0..7) in cycle i+1 after acceptance, then go to WAIT after index 7.
REQ-021 SHALL define half-sizes hw=floor(width/2), hh=floor(height/2), yt=y-hh, yb=y+hh; all coordinate arithmetic is 10-bit modulo 1024.
REQ-022 SHALL use these probe points: 0 (x,yt); 1 (x,yb); 2 (x-hw,y); 3 (x+hw,y); 4 (x-8,yb-4); 5 (x+8,yb-4); 6 (x-8,yt+4); 7 (x+8,yt+4).
REQ-023 SHALL compute address = ((px*5)>>4) + ((py*5)>>4)*MAP_W, with at least 20-bit intermediates and the result truncated to 17 bits.
REQ-024 SHALL compare rom_data one cycle after each address; flag bit i SHALL be 1 iff the word equals WALL_C0 or WALL_C1.
REQ-025 SHALL compare the index-7 data during WAIT, then go to RESP.
REQ-026 SHALL, in RESP, load rsp_flags and assert rsp_valid for exactly one cycle (cycle 10 after the accepting edge), then return to IDLE.
REQ-027 SHALL hold rsp_flags stable between RESP cycles.
REQ-028 SHALL drive rom_addr=0 in IDLE, WAIT and RESP.
REQ-029 SHALL take 11 cycles per request at most; a request held during RESP SHALL be accepted on the next edge in IDLE.

Reset
REQ-030 SHALL, while Reset=1, immediately force state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_flags=0, rom_addr=0 and clear the index and captured registers.
REQ-031 SHALL, on Reset mid-request, discard the request with no rsp_valid pulse; the first edge after release with req_valid=1 SHALL accept a new request.

Verification
REQ-032 SHALL check a single hit: x=100, y=100, width=20, height=30, ROM returns 24'h716734 only at address 5231, all else 0 -> rom_addr=5231 at cycle 1; rsp_valid at cycle 10; rsp_flags=8'h01.
REQ-033 SHALL check all-wall: ROM returns 24'h5f582b everywhere -> rsp_flags=8'hFF; ROM returns 24'h000000 everywhere -> rsp_flags=8'h00.
REQ-034 SHALL check wrap: x=3, y=100, width=20 -> left probe px=1017, rom_addr=6517 at cycle 3.
REQ-035 SHALL check reset mid-request: Reset pulsed at cycle 5 -> no rsp_valid; all outputs at reset values; next request completes normally.
REQ-036 SHALL check back-to-back and mid-request changes: req_valid held high -> accepts at edges 0 and 11, rsp_valid at cycles 10 and 21; x changed at cycle 3 -> first response unaffected.
